// File: rtl/sr_bank_controller.sv
`default_nettype none
// ============================================================================
// Module      : sr_bank_controller
// Description : Round-robin shared access to a bank of enable-gated SR
//               flip-flops. Four requesters compete for access. Each granted
//               operation pulses one cell for one clock, samples its Q and
//               returns a one-cycle ack with read data. S and R are never
//               both high at any cell.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_bank_controller #(
  parameter int NUM_CELLS = 8,
  parameter int ADDR_W    = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [3:0]           req,
  input  logic [7:0]           req_op,
  input  logic [4*ADDR_W-1:0]  req_addr,
  output logic [3:0]           ack,
  output logic                 rd_data,
  output logic                 err,
  output logic                 busy,
  output logic [NUM_CELLS-1:0] cell_s,
  output logic [NUM_CELLS-1:0] cell_r,
  output logic [NUM_CELLS-1:0] cell_e,
  input  logic [NUM_CELLS-1:0] cell_q
);

  // Full address span; cell vectors are widened to it so that any address,
  // including out-of-range ones, indexes a real bit.
  localparam int c_span = 2**ADDR_W;

  localparam logic [ADDR_W:0] c_num_cells = (ADDR_W+1)'(NUM_CELLS);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_exec   = 2'd1;
  localparam logic [1:0] c_st_sample = 2'd2;
  localparam logic [1:0] c_st_ack    = 2'd3;

  localparam logic [1:0] c_op_read   = 2'b00;
  localparam logic [1:0] c_op_set    = 2'b01;
  localparam logic [1:0] c_op_clear  = 2'b10;
  localparam logic [1:0] c_op_toggle = 2'b11;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [1:0]        r_ptr;
  logic [1:0]        r_winner;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rd_hold;

  logic              w_win_valid;
  logic [1:0]        w_win_idx;
  logic [1:0]        w_win_op;
  logic [ADDR_W-1:0] w_win_addr;
  logic              w_addr_ok;

  logic [c_span-1:0] w_q_pad;
  logic              w_q_sel;
  logic [c_span-1:0] w_s_pad;
  logic [c_span-1:0] w_r_pad;
  logic [c_span-1:0] w_e_pad;

  assign w_q_pad   = c_span'(cell_q);
  assign w_q_sel   = w_q_pad[r_addr];
  assign w_addr_ok = ({1'b0, r_addr} < c_num_cells);

  assign cell_s = w_s_pad[NUM_CELLS-1:0];
  assign cell_r = w_r_pad[NUM_CELLS-1:0];
  assign cell_e = w_e_pad[NUM_CELLS-1:0];

  // Round-robin winner search from r_ptr upward; walking offsets from high to
  // low lets the closest requester overwrite any farther candidate.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[r_ptr + 2'(k)]) begin
        w_win_valid = 1'b1;
        w_win_idx   = r_ptr + 2'(k);
      end
    end
    w_win_op   = c_op_read;
    w_win_addr = '0;
    for (int i = 0; i < 4; i++) begin
      if (w_win_idx == 2'(i)) begin
        w_win_op   = req_op[2*i +: 2];
        w_win_addr = req_addr[ADDR_W*i +: ADDR_W];
      end
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: fixed four-cycle walk once a request is granted.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:   if (w_win_valid) w_state_nxt = c_st_exec;
      c_st_exec:   w_state_nxt = c_st_sample;
      c_st_sample: w_state_nxt = c_st_ack;
      c_st_ack:    w_state_nxt = c_st_idle;
      default:     w_state_nxt = c_st_idle;
    endcase
  end

  // Grant latch, read-data capture and round-robin pointer update.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr     <= 2'd0;
      r_winner  <= 2'd0;
      r_op      <= c_op_read;
      r_addr    <= '0;
      r_rd_hold <= 1'b0;
    end else begin
      if (r_state == c_st_idle && w_win_valid) begin
        r_winner <= w_win_idx;
        r_op     <= w_win_op;
        r_addr   <= w_win_addr;
      end
      if (r_state == c_st_sample) begin
        r_rd_hold <= w_q_sel & w_addr_ok;
      end
      if (r_state == c_st_ack) begin
        r_ptr <= r_winner + 2'd1;
      end
    end
  end

  // Outputs: cell strobes only in EXEC, handshake only in ACK.
  always_comb begin
    w_s_pad = '0;
    w_r_pad = '0;
    w_e_pad = '0;
    ack     = 4'b0000;
    err     = 1'b0;
    rd_data = 1'b0;
    busy    = (r_state != c_st_idle);
    case (r_state)
      c_st_exec: begin
        if (w_addr_ok) begin
          case (r_op)
            c_op_set: begin
              w_e_pad[r_addr] = 1'b1;
              w_s_pad[r_addr] = 1'b1;
            end
            c_op_clear: begin
              w_e_pad[r_addr] = 1'b1;
              w_r_pad[r_addr] = 1'b1;
            end
            c_op_toggle: begin
              // S and R are complements of the same bit, so never both high.
              w_e_pad[r_addr] = 1'b1;
              w_s_pad[r_addr] = ~w_q_sel;
              w_r_pad[r_addr] = w_q_sel;
            end
            default: ;
          endcase
        end
      end
      c_st_ack: begin
        ack[r_winner] = 1'b1;
        err           = ~w_addr_ok;
        rd_data       = r_rd_hold & w_addr_ok;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_sr_bank_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_bank_controller
// Description : Self-checking bench for sr_bank_controller with a behavioural
//               SR cell bank, a reference model of cell contents and
//               round-robin order, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_bank_controller;

  localparam int NC = 6;
  localparam int AW = 3;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [3:0]      req = 4'b0000;
  logic [7:0]      req_op = 8'h00;
  logic [4*AW-1:0] req_addr = '0;
  logic [3:0]      ack;
  logic            rd_data;
  logic            err;
  logic            busy;
  logic [NC-1:0]   cell_s;
  logic [NC-1:0]   cell_r;
  logic [NC-1:0]   cell_e;
  logic [NC-1:0]   cell_q;
  logic [NC-1:0]   bank = '0;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: expected cell contents and round-robin pointer.
  logic mem [0:7];
  int   mptr = 0;

  always #5 clock = ~clock;

  sr_bank_controller #(.NUM_CELLS(NC), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .req(req), .req_op(req_op),
    .req_addr(req_addr), .ack(ack), .rd_data(rd_data), .err(err),
    .busy(busy), .cell_s(cell_s), .cell_r(cell_r), .cell_e(cell_e),
    .cell_q(cell_q)
  );

  // Behavioural enable-gated SR flip-flop bank, not reset by the controller.
  assign cell_q = bank;
  always @(posedge clock) begin
    for (int i = 0; i < NC; i++) begin
      if (cell_e[i]) begin
        if (cell_s[i] && !cell_r[i])      bank[i] <= 1'b1;
        else if (!cell_s[i] && cell_r[i]) bank[i] <= 1'b0;
        else if (cell_s[i] && cell_r[i])  bank[i] <= 1'bx;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Invariants sampled mid-cycle.
  always @(negedge clock) begin
    if (!reset) begin
      check("inv_s_and_r", 32'(cell_s & cell_r), 32'd0);
      check("inv_e_onehot0", 32'($onehot0(cell_e)), 32'd1);
      check("inv_ack_onehot0", 32'($onehot0(ack)), 32'd1);
      if (ack == 4'b0000) check("inv_idle_outs", {30'd0, err, rd_data}, 32'd0);
    end
  end

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // mode: 0 drop req in ACK, 1 keep req high, 2 drop req in SAMPLE,
  //       3 scramble op/addr after grant then drop req in ACK.
  task automatic expect_txn(input int w, input logic [1:0] op, input int addr, input int mode);
    logic          in_rng;
    logic          old_v;
    logic          new_v;
    logic [NC-1:0] es;
    logic [NC-1:0] ss;
    logic [NC-1:0] rs;
    in_rng = (addr < NC);
    old_v  = in_rng ? mem[addr] : 1'b0;
    case (op)
      2'b01:   new_v = 1'b1;
      2'b10:   new_v = 1'b0;
      2'b11:   new_v = ~old_v;
      default: new_v = old_v;
    endcase
    es = '0; ss = '0; rs = '0;
    if (in_rng && op != 2'b00) begin
      es[addr] = 1'b1;
      if (new_v) ss[addr] = 1'b1;
      else       rs[addr] = 1'b1;
    end
    @(posedge clock); #1;
    check("exec_e", 32'(cell_e), 32'(es));
    check("exec_s", 32'(cell_s), 32'(ss));
    check("exec_r", 32'(cell_r), 32'(rs));
    check("exec_busy", {31'd0, busy}, 32'd1);
    if (mode == 3) begin
      req_op[2*w +: 2]    = 2'($urandom);
      req_addr[AW*w +: AW] = AW'($urandom);
    end
    @(posedge clock); #1;
    check("sample_lines", 32'({cell_e, cell_s, cell_r}), 32'd0);
    check("sample_ack", 32'(ack), 32'd0);
    if (in_rng) begin
      check("cell_written", {31'd0, bank[addr]}, {31'd0, new_v});
      mem[addr] = new_v;
    end
    if (mode == 2) req[w] = 1'b0;
    @(posedge clock); #1;
    check("ack_onehot", 32'(ack), 32'(4'b0001 << w));
    check("ack_rd_data", {31'd0, rd_data}, {31'd0, in_rng ? new_v : 1'b0});
    check("ack_err", {31'd0, err}, {31'd0, !in_rng});
    mptr = (w + 1) % 4;
    if (mode != 1) req[w] = 1'b0;
    @(posedge clock); #1;
    check("idle_ack", 32'(ack), 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic drive(input int i, input logic [1:0] op, input int addr);
    req_op[2*i +: 2]     = op;
    req_addr[AW*i +: AW] = AW'(addr);
    req[i]               = 1'b1;
  endtask

  initial begin
    int            w;
    logic [3:0]    pend;
    logic [1:0]    pop [4];
    int            paddr [4];
    for (int i = 0; i < 8; i++) mem[i] = 1'b0;

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    check("reset_outs", 32'({ack, err, rd_data, busy}), 32'd0);
    check("reset_cells", 32'({cell_e, cell_s, cell_r}), 32'd0);
    reset = 1'b0;
    mptr  = 0;

    // Set cell 5 from requester 0.
    drive(0, 2'b01, 5);
    expect_txn(pick(req, mptr), 2'b01, 5, 0);

    // Toggle twice, then read.
    drive(0, 2'b11, 5);
    expect_txn(pick(req, mptr), 2'b11, 5, 0);
    drive(0, 2'b11, 5);
    expect_txn(pick(req, mptr), 2'b11, 5, 0);
    drive(0, 2'b00, 5);
    expect_txn(pick(req, mptr), 2'b00, 5, 0);

    // Bring the pointer back to 0 via requester 3.
    drive(3, 2'b00, 5);
    expect_txn(pick(req, mptr), 2'b00, 5, 0);

    // Round robin with all four requesting continuously.
    drive(0, 2'b01, 0);
    drive(1, 2'b01, 1);
    drive(2, 2'b10, 2);
    drive(3, 2'b11, 3);
    for (int n = 0; n < 5; n++) begin
      w = pick(req, mptr);
      check("rr_order", 32'(w), 32'(n % 4));
      expect_txn(w, req_op[2*w +: 2], int'(req_addr[AW*w +: AW]), 1);
    end
    req = 4'b0000;

    // Leave the pointer at 3 before the reset scenario.
    drive(2, 2'b00, 2);
    expect_txn(pick(req, mptr), 2'b00, 2, 0);

    // Reset in EXEC of a set to cell 2.
    drive(0, 2'b01, 2);
    @(posedge clock); #1;
    check("pre_reset_s", 32'(cell_s), 32'(6'b000100));
    #2 reset = 1'b1;
    #1;
    check("reset_mid_outs", 32'({ack, err, rd_data, busy, cell_e, cell_s, cell_r}), 32'd0);
    req = 4'b0000;
    repeat (2) @(posedge clock);
    #1;
    check("reset_no_write", {31'd0, bank[2]}, {31'd0, mem[2]});
    reset = 1'b0;
    mptr  = 0;
    drive(2, 2'b00, 2);
    drive(3, 2'b01, 4);
    w = pick(req, mptr);
    check("post_reset_winner", 32'(w), 32'd2);
    expect_txn(w, 2'b00, 2, 0);
    expect_txn(pick(req, mptr), 2'b01, 4, 0);

    // Out-of-range address.
    drive(0, 2'b01, 7);
    expect_txn(pick(req, mptr), 2'b01, 7, 0);

    // Requester 1 drops req during SAMPLE.
    drive(1, 2'b10, 4);
    expect_txn(pick(req, mptr), 2'b10, 4, 2);

    // Random contention against the reference model.
    pend = 4'b0000;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]  = 1'b1;
          pop[i]   = 2'($urandom);
          paddr[i] = $urandom_range(0, 7);
        end
      end
      if (pend == 4'b0000) begin
        pend[0]  = 1'b1;
        pop[0]   = 2'($urandom);
        paddr[0] = $urandom_range(0, 7);
      end
      for (int i = 0; i < 4; i++) if (pend[i]) drive(i, pop[i], paddr[i]);
      w = pick(pend, mptr);
      expect_txn(w, pop[w], paddr[w], 3);
      pend[w] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
